// File: rtl/tqvp_gera_gray_pkg.sv
`default_nettype none
// ============================================================================
// Package : tqvp_gera_gray_pkg
// Brief   : Mode encodings, register map and bit indices for the Gray engine.
// Rev     : 1.0  initial release
// ============================================================================
package tqvp_gera_gray_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_B2G  = 2'b01,
    MODE_G2B  = 2'b10,
    MODE_CNT  = 2'b11
  } mode_e;

  typedef enum logic [0:0] {
    G2B_IDLE = 1'b0,
    G2B_RUN  = 1'b1
  } g2b_state_e;

  localparam logic [3:0] c_addr_ctrl     = 4'h0;
  localparam logic [3:0] c_addr_status   = 4'h1;
  localparam logic [3:0] c_addr_in_base  = 4'h4;
  localparam logic [3:0] c_addr_out_base = 4'h8;
  localparam logic [3:0] c_addr_prescale = 4'hC;

  localparam int c_ctrl_cnt_en   = 2;
  localparam int c_ctrl_cnt_down = 3;
  localparam int c_ctrl_clear    = 4;

  localparam int c_st_busy    = 0;
  localparam int c_st_done    = 1;
  localparam int c_st_wrap    = 2;
  localparam int c_st_overrun = 3;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tqvp_gera_gray_g2b_iter.sv
`default_nettype none
// ============================================================================
// Module : tqvp_gera_gray_g2b_iter
// Brief  : Iterative Gray-to-binary decoder, one bit per cycle, MSB first.
// Rev    : 1.0  initial release
// ============================================================================
module tqvp_gera_gray_g2b_iter
  import tqvp_gera_gray_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  localparam int c_cw = $clog2(WIDTH);
  localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);

  g2b_state_e       state_q, state_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [c_cw-1:0]  step_q, step_d;
  logic             bit_new;

  // Each decoded bit is the previous binary bit XOR the current Gray bit.
  assign bit_new = acc_q[0] ^ gray_q[WIDTH-1];
  assign out     = {acc_q[WIDTH-2:0], bit_new};
  assign busy    = (state_q == G2B_RUN);

  always_comb begin
    state_d = state_q;
    gray_d  = gray_q;
    acc_d   = acc_q;
    step_d  = step_q;
    done    = 1'b0;
    case (state_q)
      G2B_IDLE: begin
        if (start && !abort) begin
          state_d = G2B_RUN;
          gray_d  = in;
          acc_d   = '0;
          step_d  = '0;
        end
      end
      G2B_RUN: begin
        acc_d  = out;
        gray_d = {gray_q[WIDTH-2:0], 1'b0};
        step_d = step_q + 1'b1;
        if (abort) begin
          state_d = G2B_IDLE;
        end else if (step_q == c_last) begin
          done    = 1'b1;
          state_d = G2B_IDLE;
        end
      end
      default: state_d = G2B_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= G2B_IDLE;
      gray_q  <= '0;
      acc_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      gray_q  <= gray_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tqvp_gera_gray_engine.sv
`default_nettype none
// ============================================================================
// Module : tqvp_gera_gray_engine
// Brief  : Register-mapped Gray encoder/decoder with optional Gray counter.
//          Define GRAY_COUNTER_EN to build MODE 11 counter and prescaler.
// Rev    : 1.0  initial release
// ============================================================================
module tqvp_gera_gray_engine
  import tqvp_gera_gray_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int c_nb = WIDTH / 8;
  localparam logic [1:0] c_last_byte = 2'(c_nb - 1);

  logic [3:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] in_q, in_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;

  logic             ctrl_wr, status_wr, clear, in_wr, launch, launch_ok;
  logic             mode_accepts, done_set;
  logic             g2b_start, g2b_abort, g2b_busy, g2b_done;
  logic [WIDTH-1:0] g2b_out, operand;
  mode_e            mode;

  logic             wrap_flag;
  logic [7:0]       prescale_rd;
  logic             cnt_mode_active;
  logic [WIDTH-1:0] cnt_gray;
  logic             unused_sig;

  assign unused_sig = &{1'b0, ui_in};
  assign mode       = mode_e'(ctrl_q[1:0]);
  assign uo_out     = out_q[7:0];

  assign ctrl_wr   = data_write && (address == c_addr_ctrl);
  assign status_wr = data_write && (address == c_addr_status);
  assign clear     = ctrl_wr && data_in[c_ctrl_clear];
  assign in_wr     = data_write && (address[3:2] == c_addr_in_base[3:2])
                     && (32'(address[1:0]) < c_nb);
  assign launch    = in_wr && (address[1:0] == c_last_byte);
  assign launch_ok = launch && !g2b_busy && mode_accepts;

  assign g2b_start = launch_ok && (mode == MODE_G2B);
  // Any CTRL write while decoding abandons it; CLEAR aborts unconditionally.
  assign g2b_abort = clear || (ctrl_wr && g2b_busy);

  tqvp_gera_gray_g2b_iter #(
    .WIDTH(WIDTH)
  ) u_g2b (
    .clk  (clk),
    .rst  (rst),
    .start(g2b_start),
    .abort(g2b_abort),
    .in   (operand),
    .busy (g2b_busy),
    .done (g2b_done),
    .out  (g2b_out)
  );

`ifdef GRAY_COUNTER_EN
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]       pre_q, pre_d;
  logic [7:0]       prescale_q, prescale_d;
  logic             wrap_q, wrap_d;
  logic             cnt_run, cnt_step, cnt_load, wrap_set;

  assign mode_accepts = (mode != MODE_IDLE);

  always_comb begin
    cnt_run  = (mode == MODE_CNT) && ctrl_q[c_ctrl_cnt_en];
    cnt_step = cnt_run && (pre_q == prescale_q);
    cnt_load = launch_ok && (mode == MODE_CNT);
    cnt_d    = cnt_q;
    wrap_set = 1'b0;
    // A load in the same cycle as a step discards the step.
    if (cnt_load) begin
      cnt_d = operand;
    end else if (cnt_step) begin
      if (ctrl_q[c_ctrl_cnt_down]) begin
        cnt_d    = cnt_q - 1'b1;
        wrap_set = (cnt_q == '0);
      end else begin
        cnt_d    = cnt_q + 1'b1;
        wrap_set = &cnt_q;
      end
    end
    pre_d      = (!cnt_run || ctrl_wr || cnt_step) ? 8'd0 : pre_q + 8'd1;
    prescale_d = (data_write && (address == c_addr_prescale)) ? data_in : prescale_q;
    wrap_d     = (wrap_q & ~(status_wr & data_in[c_st_wrap])) | wrap_set;
    if (clear) begin
      cnt_d  = '0;
      pre_d  = 8'd0;
      wrap_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      pre_q      <= 8'd0;
      prescale_q <= 8'd0;
      wrap_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pre_q      <= pre_d;
      prescale_q <= prescale_d;
      wrap_q     <= wrap_d;
    end
  end

  assign wrap_flag       = wrap_q;
  assign prescale_rd     = prescale_q;
  assign cnt_mode_active = (mode == MODE_CNT);
  assign cnt_gray        = WIDTH'(bin2gray(32'(cnt_d)));
`else
  assign mode_accepts    = (mode == MODE_B2G) || (mode == MODE_G2B);
  assign wrap_flag       = 1'b0;
  assign prescale_rd     = 8'd0;
  assign cnt_mode_active = 1'b0;
  assign cnt_gray        = '0;
`endif

  // Staged operand includes the byte being written this cycle.
  always_comb begin
    operand = in_q;
    if (in_wr) begin
      for (int j = 0; j < c_nb; j++) begin
        if (address[1:0] == 2'(j)) operand[8*j +: 8] = data_in;
      end
    end
    in_d = clear ? '0 : operand;
  end

  always_comb begin
    done_set = (launch_ok && (mode == MODE_B2G)) || g2b_done;
    ctrl_d   = ctrl_wr ? data_in[3:0] : ctrl_q;
    out_d    = out_q;
    if (launch_ok && (mode == MODE_B2G)) out_d = WIDTH'(bin2gray(32'(operand)));
    if (g2b_done) out_d = g2b_out;
    if (cnt_mode_active) out_d = cnt_gray;
    done_d    = (done_q & ~(status_wr & data_in[c_st_done])) | done_set;
    overrun_d = (overrun_q & ~(status_wr & data_in[c_st_overrun])) | (launch && g2b_busy);
    if (clear) begin
      out_d     = '0;
      done_d    = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= 4'd0;
      in_q      <= '0;
      out_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      in_q      <= in_d;
      out_q     <= out_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    data_out = 8'h00;
    case (address)
      c_addr_ctrl: data_out = {4'h0, ctrl_q};
      c_addr_status: begin
        data_out[c_st_busy]    = g2b_busy;
        data_out[c_st_done]    = done_q;
        data_out[c_st_wrap]    = wrap_flag;
        data_out[c_st_overrun] = overrun_q;
      end
      c_addr_prescale: data_out = prescale_rd;
      default: begin
        if (address[3:2] == c_addr_out_base[3:2]) begin
          for (int j = 0; j < c_nb; j++) begin
            if (address[1:0] == 2'(j)) data_out = out_q[8*j +: 8];
          end
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_tqvp_gera_gray_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_tqvp_gera_gray_engine
// Brief  : Scoreboard bench for the Gray engine (WIDTH=16); counter checks
//          are selected by GRAY_COUNTER_EN.
// Rev    : 1.0  initial release
// ============================================================================
module tb_tqvp_gera_gray_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out;
  logic [3:0] address = 4'h0;
  logic       data_write = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;

  typedef struct packed {
    logic        uo;
    logic [7:0]  exp;
    logic [95:0] nm;
  } chk_t;

  chk_t sb_q[$];
  logic chk_req = 1'b0;
  logic drain_req = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  tqvp_gera_gray_engine #(
    .WIDTH(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ui_in     (ui_in),
    .uo_out    (uo_out),
    .address   (address),
    .data_write(data_write),
    .data_in   (data_in),
    .data_out  (data_out)
  );

  always @(negedge clk) begin
    chk_t       c;
    logic [7:0] act;
    if (chk_req) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_empty: got a read with no expected value queued");
      end else begin
        c   = sb_q.pop_front();
        act = c.uo ? uo_out : data_out;
        if (act !== c.exp) begin
          bad++;
          $display("FAIL %0s: got 0x%02h expected 0x%02h", c.nm, act, c.exp);
        end
      end
    end
    if (drain_req) begin
      total++;
      if (sb_q.size() != 0) begin
        bad++;
        $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    address    = a;
    data_in    = d;
    data_write = 1'b1;
    tick();
    data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] e, input logic [95:0] nm);
    address = a;
    sb_q.push_back(chk_t'{1'b0, e, nm});
    chk_req = 1'b1;
    tick();
    chk_req = 1'b0;
  endtask

  task automatic rd_uo(input logic [7:0] e, input logic [95:0] nm);
    sb_q.push_back(chk_t'{1'b1, e, nm});
    chk_req = 1'b1;
    tick();
    chk_req = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] presc_tbl [13];
    presc_tbl = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01,
                  8'h03, 8'h03, 8'h03, 8'h03, 8'h02};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    rd(4'h0, 8'h00, "rst_ctrl");
    rd(4'h1, 8'h00, "rst_status");
    rd(4'h8, 8'h00, "rst_out0");
    rd_uo(8'h00, "rst_uo");

    // Binary to Gray
    wr(4'h0, 8'h01);
    wr(4'h4, 8'h34);
    wr(4'h5, 8'h12);
    rd(4'h8, 8'h2E, "b2g_out0");
    rd(4'h9, 8'h1B, "b2g_out1");
    rd(4'h1, 8'h02, "b2g_done");
    rd_uo(8'h2E, "b2g_uo");
    wr(4'h4, 8'hFF);
    wr(4'h5, 8'hFF);
    rd(4'h8, 8'h00, "b2g_ff_lo");
    rd(4'h9, 8'h80, "b2g_ff_hi");
    wr(4'h4, 8'h01);
    rd(4'h9, 8'h80, "stage_noeff");
    wr(4'h5, 8'h00);
    rd(4'h8, 8'h01, "b2g_one_lo");
    rd(4'h9, 8'h00, "b2g_one_hi");
    rd(4'h4, 8'h00, "in_rd_zero");

    // Gray to binary with overrun at busy cycle 5
    wr(4'h1, 8'h0E);
    rd(4'h1, 8'h00, "w1c_all");
    wr(4'h0, 8'h02);
    wr(4'h4, 8'h2E);
    wr(4'h5, 8'h1B);
    for (int i = 0; i < 4; i++) rd(4'h1, 8'h01, "g2b_busy");
    wr(4'h5, 8'h55);
    for (int i = 0; i < 10; i++) rd(4'h1, 8'h09, "g2b_ovr");
    rd(4'h8, 8'h01, "g2b_hold");
    rd(4'h1, 8'h0A, "g2b_done");
    rd(4'h8, 8'h34, "g2b_out0");
    rd(4'h9, 8'h12, "g2b_out1");

    // Abort by MODE write, then a full decode of 0x8000
    wr(4'h1, 8'h0E);
    wr(4'h4, 8'h00);
    wr(4'h5, 8'h80);
    idle(2);
    wr(4'h0, 8'h02);
    rd(4'h1, 8'h00, "abort_st");
    idle(20);
    rd(4'h1, 8'h00, "abort_nodone");
    rd(4'h9, 8'h12, "abort_out");
    wr(4'h5, 8'h80);
    idle(16);
    rd(4'h9, 8'hFF, "g2b_ff_hi");
    rd(4'h8, 8'hFF, "g2b_ff_lo");

    // Write-1-clear coinciding with DONE set
    wr(4'h1, 8'h0E);
    wr(4'h5, 8'h80);
    idle(15);
    wr(4'h1, 8'h02);
    rd(4'h1, 8'h02, "w1c_set_wins");
    wr(4'h1, 8'h02);
    rd(4'h1, 8'h00, "w1c_clear");

    // CLEAR during a decode
    wr(4'h4, 8'h0F);
    wr(4'h5, 8'h80);
    idle(3);
    wr(4'h0, 8'h12);
    rd(4'h1, 8'h00, "clr_status");
    rd(4'h8, 8'h00, "clr_out0");
    rd(4'h9, 8'h00, "clr_out1");
    rd_uo(8'h00, "clr_uo");
    idle(20);
    rd(4'h1, 8'h00, "clr_nodone");
    wr(4'h5, 8'h01);
    idle(16);
    rd(4'h8, 8'hFF, "clr_in_lo");
    rd(4'h9, 8'h01, "clr_in_hi");

    // Reset during a decode
    wr(4'hC, 8'h05);
    wr(4'h5, 8'h80);
    idle(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd(4'h0, 8'h00, "rst2_ctrl");
    rd(4'h1, 8'h00, "rst2_status");
    rd(4'h8, 8'h00, "rst2_out0");
    rd(4'h9, 8'h00, "rst2_out1");
    rd(4'hC, 8'h00, "rst2_presc");
    idle(20);
    rd(4'h1, 8'h00, "rst2_nodone");

    // MODE 00 ignores launches
    wr(4'h4, 8'h12);
    wr(4'h5, 8'h34);
    rd(4'h9, 8'h00, "idle_out");
    rd(4'h1, 8'h00, "idle_flags");

`ifdef GRAY_COUNTER_EN
    wr(4'h0, 8'h03);
    wr(4'h4, 8'hFF);
    wr(4'h5, 8'hFF);
    rd(4'h9, 8'h80, "cnt_load");
    wr(4'h0, 8'h07);
    rd(4'h9, 8'h80, "cnt_pre_wrap");
    rd(4'h9, 8'h00, "cnt_wrap");
    rd(4'h1, 8'h04, "cnt_wrap_flag");
    wr(4'h0, 8'h03);
    wr(4'h4, 8'h00);
    wr(4'h5, 8'h00);
    wr(4'h1, 8'h04);
    wr(4'h0, 8'h0F);
    rd(4'h9, 8'h00, "cnt_dn_zero");
    rd(4'h9, 8'h80, "cnt_dn_wrap");
    rd(4'h1, 8'h04, "cnt_dn_flag");
    wr(4'h4, 8'h10);
    wr(4'h5, 8'h00);
    rd(4'h8, 8'h18, "load_wins");
    rd(4'h8, 8'h08, "after_load");
    wr(4'h0, 8'h03);
    wr(4'hC, 8'h03);
    rd(4'hC, 8'h03, "presc_rd");
    wr(4'h4, 8'h00);
    wr(4'h5, 8'h00);
    wr(4'h0, 8'h07);
    for (int i = 0; i < 13; i++) rd(4'h8, presc_tbl[i], "presc_seq");
`else
    wr(4'h0, 8'h01);
    wr(4'h4, 8'h34);
    wr(4'h5, 8'h12);
    wr(4'h1, 8'h0E);
    wr(4'h0, 8'h07);
    wr(4'h4, 8'hAA);
    wr(4'h5, 8'h55);
    idle(3);
    rd(4'h8, 8'h2E, "nocnt_out0");
    rd(4'h9, 8'h1B, "nocnt_out1");
    rd(4'h1, 8'h00, "nocnt_flags");
    wr(4'hC, 8'h03);
    rd(4'hC, 8'h00, "nocnt_presc");
    rd(4'h0, 8'h07, "nocnt_ctrl");
`endif

    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
